cpu_controller: RTL

- Upstream control stage for the 16-bit register/ALU datapath.
- Holds the instruction register (IR), the program counter (PC) and the data-address register, and decodes the IR.
- Sequences a Moore FSM that drives every datapath control input (readnum, vsel, loada/b/c, loads, asel, bsel, shift, ALUop, writenum, write, sximm8, sximm5, PC).
- Drives the command and address of the single-port instruction/data memory.

---
 rtl/cpu_controller_if.sv | 38 +++
 rtl/cpu_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller_if.sv
// Control and memory bus between the CPU controller and the datapath/memory.
// Memory protocol: mem_addr with mem_cmd=READ in one cycle returns mdata in the
// next cycle; mem_cmd=WRITE is a single-cycle write to mem_addr. There is no
// backpressure: the memory accepts every command in the cycle it is issued.
interface cpu_controller_if;
    logic [15:0] mdata;
    logic [15:0] datapath_out;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [7:0]  PC;
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr;
    logic        halted;

    modport master (
        input  mdata, datapath_out,
        output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, PC, mem_cmd, mem_addr, halted
    );

    modport slave (
        output mdata, datapath_out,
        input  readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, PC, mem_cmd, mem_addr, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Control stage for the 16-bit register/ALU datapath: holds IR, PC and the data
// address, decodes the IR and sequences a Moore FSM that drives every datapath
// control and the single-port memory command/address.
module cpu_controller #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    cpu_controller_if.master   bus,
    output logic [4:0]         state_o
);
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_MOV_IMM, S_GET_A, S_GET_B,
        S_ALU, S_WRITE_REG, S_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WB_MEM, S_STR_GETB,
        S_STR_C, S_MEM_WR, S_HALT
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  daddr_q, daddr_d;

    // IR fields and instruction classes
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp, is_ldr, is_str, is_halt;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
    assign is_str     = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt    = (opcode == 3'b111) && (op == 2'b00);

    assign state_o = state_q;

    // State register; reset abandons whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // Architectural registers: PC, IR and data address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            daddr_q <= 8'h00;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            daddr_q <= daddr_d;
        end
    end

    // Next values of the architectural registers, each updated in one state only
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        daddr_d = daddr_q;
        if (state_q == S_UPDATE_PC) pc_d = pc_q + 8'd1;
        if (state_q == S_IF2)       ir_d = bus.mdata;
        if (state_q == S_LOAD_ADDR) daddr_d = bus.datapath_out[7:0];
    end

    // Next-state logic; unrecognised encodings fall back to fetch as a NOP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_d = S_MOV_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else if (is_ldr || is_str)     state_d = S_GET_A;
                else if (is_halt)              state_d = S_HALT;
                else                           state_d = S_IF1;
            end
            S_MOV_IMM:   state_d = S_IF1;
            S_GET_A:     state_d = (is_ldr || is_str) ? S_ADDR : S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_IF1 : S_WRITE_REG;
            S_WRITE_REG: state_d = S_IF1;
            S_ADDR:      state_d = S_LOAD_ADDR;
            S_LOAD_ADDR: state_d = is_ldr ? S_MEM_RD : S_STR_GETB;
            S_MEM_RD:    state_d = S_WB_MEM;
            S_WB_MEM:    state_d = S_IF1;
            S_STR_GETB:  state_d = S_STR_C;
            S_STR_C:     state_d = S_MEM_WR;
            S_MEM_WR:    state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RST;
        endcase
    end

    // Moore outputs decoded from state and IR only
    always_comb begin
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.vsel     = 4'b0001;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;
        bus.mem_cmd  = CMD_NONE;
        bus.mem_addr = pc_q;
        bus.halted   = 1'b0;
        case (state_q)
            S_IF1, S_IF2: bus.mem_cmd = CMD_READ;
            S_MOV_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 4'b0010;
                bus.write    = 1'b1;
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            S_ALU: begin
                // MOV reg (op=00) and MVN (op=11) already carry their ALU op in the op field
                bus.asel  = is_mov_reg || is_mvn;
                bus.shift = sh;
                bus.ALUop = op;
                bus.loadc = !is_cmp;
                bus.loads = is_cmp;
            end
            S_WRITE_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
            end
            S_ADDR: begin
                bus.bsel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_MEM_RD: begin
                bus.mem_addr = daddr_q;
                bus.mem_cmd  = CMD_READ;
            end
            S_WB_MEM: begin
                bus.mem_addr = daddr_q;
                bus.mem_cmd  = CMD_READ;
                bus.writenum = rd;
                bus.vsel     = 4'b0100;
                bus.write    = 1'b1;
            end
            S_STR_GETB: begin
                bus.readnum = rd;
                bus.loadb   = 1'b1;
            end
            S_STR_C: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_addr = daddr_q;
                bus.mem_cmd  = CMD_WRITE;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    // Immediates straight from the IR
    assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign bus.PC     = pc_q;
endmodule
